// File: rtl/discrete_filter_pkg.sv
// Shared definitions for the discrete filter sequencer.
//   - fsm_state_t   : sequencer states
//   - filter_mode_t : per-channel filter type (low-pass / high-pass)
//   - SIGNAL_WIDTH, FRACTION_WIDTH, SAT_MAX, SAT_MIN : datapath constants
package discrete_filter_pkg;

  localparam int SIGNAL_WIDTH   = 16;
  localparam int FRACTION_WIDTH = 16;
  localparam int SAT_MAX        = 32767;
  localparam int SAT_MIN        = -32768;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OPERAND   = 3'd1,
    ST_MULTIPLY  = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_DONE      = 3'd4
  } fsm_state_t;

  typedef enum logic {
    MODE_LP = 1'b0,
    MODE_HP = 1'b1
  } filter_mode_t;

endpackage

// File: rtl/filter_mac_unit.sv
// One combinational filter step for a single channel.
// Ports:
//   mode    in  filter type (low-pass / high-pass)
//   alpha   in  Q0.16 unsigned smoothing factor
//   x       in  current input sample (signed)
//   y       in  current filter state (signed)
//   x_prev  in  previous input sample, used by high-pass (signed)
//   result  out saturated next filter state
//   sat     out result was clipped
module filter_mac_unit
  import discrete_filter_pkg::*;
(
  input  filter_mode_t       mode,
  input  logic [15:0]        alpha,
  input  logic signed [15:0] x,
  input  logic signed [15:0] y,
  input  logic signed [15:0] x_prev,
  output logic signed [15:0] result,
  output logic               sat
);

  localparam logic signed [19:0] MAX20 = 20'(SAT_MAX);
  localparam logic signed [19:0] MIN20 = 20'(SAT_MIN);

  logic signed [17:0] x_e, y_e, xp_e, term;
  logic signed [16:0] alpha_s;
  logic signed [34:0] prod;
  logic signed [18:0] scaled;
  logic signed [19:0] sum;

  always_comb begin
    x_e     = {{2{x[15]}}, x};
    y_e     = {{2{y[15]}}, y};
    xp_e    = {{2{x_prev[15]}}, x_prev};
    alpha_s = {1'b0, alpha};
    if (mode == MODE_HP) term = y_e + x_e - xp_e;
    else                 term = x_e - y_e;
    prod   = alpha_s * term;
    // Taking the upper bits of a signed product is an arithmetic shift (floor).
    scaled = prod[34:FRACTION_WIDTH];
    if (mode == MODE_HP) sum = {scaled[18], scaled};
    else                 sum = {{4{y[15]}}, y} + {scaled[18], scaled};
    sat    = 1'b0;
    result = sum[15:0];
    if (sum > MAX20) begin
      result = 16'sh7fff;
      sat    = 1'b1;
    end else if (sum < MIN20) begin
      result = 16'sh8000;
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/discrete_filter_sequencer.sv
// Time-multiplexed first-order filter bank: NUM_CHANNELS channels share one
// filter_mac_unit, each channel taking OPERAND -> MULTIPLY -> WRITEBACK.
// Ports:
//   clk, I_RST        clock, synchronous active-high reset
//   audio_clk_en      sample strobe (one clk)
//   in                per-channel signed input samples
//   cfg_we/cfg_addr   configuration write strobe and channel
//   cfg_alpha/mode/enable  configuration data
//   clr_overrun       clears the sticky overrun flag
//   out, out_valid    registered filtered outputs and their update pulse
//   busy              a sample is being processed
//   overrun           sticky: a strobe arrived while busy
//   saturated         sticky: a result was clipped during the last sample
//   dbg_state         current sequencer state
//
// Handshake: audio_clk_en is fire-and-forget; it is accepted only in IDLE.
// A strobe in any other state is dropped and flagged via overrun.
module discrete_filter_sequencer
  import discrete_filter_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  localparam int AW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          I_RST,
  input  logic                          audio_clk_en,
  input  logic [NUM_CHANNELS-1:0][15:0] in,
  input  logic                          cfg_we,
  input  logic [AW-1:0]                 cfg_addr,
  input  logic [15:0]                   cfg_alpha,
  input  logic                          cfg_mode,
  input  logic                          cfg_enable,
  input  logic                          clr_overrun,
  output logic [NUM_CHANNELS-1:0][15:0] out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun,
  output logic                          saturated,
  output logic [2:0]                    dbg_state
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CHANNELS - 1);

  // Live configuration (written any time) and its snapshot taken at capture.
  logic [15:0]        alpha_cfg [NUM_CHANNELS];
  filter_mode_t       mode_cfg  [NUM_CHANNELS];
  logic               en_cfg    [NUM_CHANNELS];
  logic [15:0]        alpha_l   [NUM_CHANNELS];
  filter_mode_t       mode_l    [NUM_CHANNELS];
  logic               en_l      [NUM_CHANNELS];
  logic signed [15:0] x_l       [NUM_CHANNELS];
  logic signed [15:0] y_st      [NUM_CHANNELS];
  logic signed [15:0] xp_st     [NUM_CHANNELS];

  fsm_state_t         state;
  logic [AW-1:0]      idx;
  logic [15:0]        op_alpha;
  filter_mode_t       op_mode;
  logic               op_en;
  logic signed [15:0] op_x, op_y, op_xp;
  logic signed [15:0] res_q, mac_result;
  logic               res_sat_q, mac_sat;

  assign dbg_state = state;

  filter_mac_unit u_mac (
    .mode   (op_mode),
    .alpha  (op_alpha),
    .x      (op_x),
    .y      (op_y),
    .x_prev (op_xp),
    .result (mac_result),
    .sat    (mac_sat)
  );

  always_ff @(posedge clk) begin
    if (I_RST) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        alpha_cfg[c] <= '0;
        mode_cfg[c]  <= MODE_LP;
        en_cfg[c]    <= 1'b0;
      end
    end else if (cfg_we && (int'(cfg_addr) < NUM_CHANNELS)) begin
      alpha_cfg[cfg_addr] <= cfg_alpha;
      mode_cfg[cfg_addr]  <= filter_mode_t'(cfg_mode);
      en_cfg[cfg_addr]    <= cfg_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (I_RST) begin
      state     <= ST_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      saturated <= 1'b0;
      op_alpha  <= '0;
      op_mode   <= MODE_LP;
      op_en     <= 1'b0;
      op_x      <= '0;
      op_y      <= '0;
      op_xp     <= '0;
      res_q     <= '0;
      res_sat_q <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        y_st[c]    <= '0;
        xp_st[c]   <= '0;
        out[c]     <= '0;
        alpha_l[c] <= '0;
        mode_l[c]  <= MODE_LP;
        en_l[c]    <= 1'b0;
        x_l[c]     <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      // A new overrun event wins over a simultaneous clear.
      if (audio_clk_en && (state != ST_IDLE)) overrun <= 1'b1;
      else if (clr_overrun)                   overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (audio_clk_en) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
              x_l[c]     <= in[c];
              alpha_l[c] <= alpha_cfg[c];
              mode_l[c]  <= mode_cfg[c];
              en_l[c]    <= en_cfg[c];
            end
            busy      <= 1'b1;
            saturated <= 1'b0;
            idx       <= '0;
            state     <= ST_OPERAND;
          end
        end
        ST_OPERAND: begin
          op_alpha <= alpha_l[idx];
          op_mode  <= mode_l[idx];
          op_en    <= en_l[idx];
          op_x     <= x_l[idx];
          op_y     <= y_st[idx];
          op_xp    <= xp_st[idx];
          state    <= ST_MULTIPLY;
        end
        ST_MULTIPLY: begin
          res_q     <= mac_result;
          res_sat_q <= mac_sat;
          state     <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          if (op_en) begin
            y_st[idx] <= res_q;
            if (op_mode == MODE_HP) xp_st[idx] <= op_x;
            if (res_sat_q) saturated <= 1'b1;
          end else begin
            // Disabled channels still consume their slot to keep latency fixed.
            y_st[idx]  <= '0;
            xp_st[idx] <= '0;
          end
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_OPERAND;
          end
        end
        ST_DONE: begin
          for (int c = 0; c < NUM_CHANNELS; c++) out[c] <= y_st[c];
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_discrete_filter_sequencer.sv
module tb_discrete_filter_sequencer;

  localparam int NCH = 4;

  logic                 clk = 1'b0;
  logic                 I_RST = 1'b1;
  logic                 audio_clk_en = 1'b0;
  logic [NCH-1:0][15:0] in_s = '0;
  logic                 cfg_we = 1'b0;
  logic [1:0]           cfg_addr = '0;
  logic [15:0]          cfg_alpha = '0;
  logic                 cfg_mode = 1'b0;
  logic                 cfg_enable = 1'b0;
  logic                 clr_overrun = 1'b0;
  logic [NCH-1:0][15:0] out_s;
  logic                 out_valid, busy, overrun, saturated;
  logic [2:0]           dbg_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int x[NCH];
    int e[NCH];
    int sat;
  } vec_t;

  vec_t tbl[4];

  discrete_filter_sequencer #(.NUM_CHANNELS(NCH)) dut (
    .clk          (clk),
    .I_RST        (I_RST),
    .audio_clk_en (audio_clk_en),
    .in           (in_s),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_alpha    (cfg_alpha),
    .cfg_mode     (cfg_mode),
    .cfg_enable   (cfg_enable),
    .clr_overrun  (clr_overrun),
    .out          (out_s),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .saturated    (saturated),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    I_RST = 1'b1;
    repeat (2) @(posedge clk);
    #1 I_RST = 1'b0;
    @(negedge clk);
    check({tag, " state"}, 32'(dbg_state), 0);
    check({tag, " flags"}, {28'd0, out_valid, busy, overrun, saturated}, 0);
    for (int c = 0; c < NCH; c++)
      check($sformatf("%s out%0d", tag, c), $signed(out_s[c]), 0);
  endtask

  // driver tasks
  task automatic cfg_write(input int ch, input int alpha, input bit mode, input bit en);
    cfg_we     = 1'b1;
    cfg_addr   = 2'(ch);
    cfg_alpha  = 16'(alpha);
    cfg_mode   = mode;
    cfg_enable = en;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) begin
      check("out_valid timeout", 0, 1);
      n = -1;
    end
  endtask

  task automatic count_valid(input int cycles, output int k);
    k = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (out_valid) k++;
    end
  endtask

  // strobe, check capture, latency and pulse width
  task automatic strobe_check(input string tag);
    int n;
    audio_clk_en = 1'b1;
    @(posedge clk);
    #1 audio_clk_en = 1'b0;
    check({tag, " busy"}, 32'(busy), 1);
    wait_valid(n);
    check({tag, " latency"}, n, 13);
    @(negedge clk);
    check({tag, " pulse"}, 32'(out_valid), 0);
  endtask

  initial begin
    int k;
    int n;

    // {inputs, expected outputs, expected saturated}
    tbl[0] = '{x: '{1000, 1000, -32768, 500},  e: '{500, 500, -32768, 0}, sat: 0};
    tbl[1] = '{x: '{1000, 1000, 32767, -700},  e: '{750, 250, 32766, 0},  sat: 0};
    tbl[2] = '{x: '{1000, 1000, -32768, 123},  e: '{875, 125, -32768, 0}, sat: 1};
    tbl[3] = '{x: '{-1000, -1000, 0, 9},       e: '{-63, -938, 0, 0},     sat: 0};

    do_reset("rst0");

    cfg_write(0, 32768, 1'b0, 1'b1);
    cfg_write(1, 32768, 1'b1, 1'b1);
    cfg_write(2, 65535, 1'b1, 1'b1);
    cfg_write(3, 1000,  1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < NCH; c++) in_s[c] = 16'(tbl[i].x[c]);
      strobe_check($sformatf("vec%0d", i));
      for (int c = 0; c < NCH; c++)
        check($sformatf("vec%0d out%0d", i, c), $signed(out_s[c]), tbl[i].e[c]);
      check($sformatf("vec%0d sat", i), 32'(saturated), tbl[i].sat);
    end

    // overrun: second strobe 5 clk after capture
    audio_clk_en = 1'b1;
    @(posedge clk);
    #1 audio_clk_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 audio_clk_en = 1'b1;
    @(posedge clk);
    #1 audio_clk_en = 1'b0;
    check("ovr set", 32'(overrun), 1);
    count_valid(25, k);
    check("ovr valid count", k, 1);
    check("ovr sticky", 32'(overrun), 1);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    check("ovr cleared", 32'(overrun), 0);

    // clear and new overrun event on the same edge
    audio_clk_en = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b1;
    @(posedge clk);
    #1 audio_clk_en = 1'b0;
    clr_overrun = 1'b0;
    check("ovr set wins", 32'(overrun), 1);
    count_valid(20, k);
    check("ovr2 valid count", k, 1);

    // cfg write mid-sample affects only the next sample
    do_reset("rst1");
    cfg_write(0, 32768, 1'b0, 1'b1);
    in_s = '0;
    in_s[0] = 16'd1000;
    audio_clk_en = 1'b1;
    @(posedge clk);
    #1 audio_clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cfg_write(0, 16384, 1'b0, 1'b1);
    wait_valid(n);
    check("cfg old alpha", $signed(out_s[0]), 500);
    strobe_check("cfg2");
    check("cfg new alpha", $signed(out_s[0]), 625);

    // reset mid-sample aborts without out_valid
    audio_clk_en = 1'b1;
    @(posedge clk);
    #1 audio_clk_en = 1'b0;
    repeat (6) @(posedge clk);
    #1 I_RST = 1'b1;
    @(posedge clk);
    #1 I_RST = 1'b0;
    count_valid(20, k);
    check("abort valid count", k, 0);
    check("abort state", 32'(dbg_state), 0);
    check("abort flags", {28'd0, out_valid, busy, overrun, saturated}, 0);
    for (int c = 0; c < NCH; c++)
      check($sformatf("abort out%0d", c), $signed(out_s[c]), 0);
    cfg_write(0, 32768, 1'b0, 1'b1);
    in_s[0] = 16'd1000;
    strobe_check("post");
    check("post out0", $signed(out_s[0]), 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/discrete_filter_sequencer.md
DISCRETE_FILTER_SEQUENCER -- requirements
Module: discrete_filter_sequencer

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of first-order filter channels sharing one multiplier.
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 I_RST  in  1  reset; synchronous, active-high.
REQ-004 audio_clk_en  in  1  sample strobe, one clk wide.
REQ-005 in  in  NUM_CHANNELS x 16 signed  per-channel input samples.
REQ-006 cfg_we  in  1  configuration write strobe.
REQ-007 cfg_addr  in  clog2(NUM_CHANNELS)  target channel of the write.
REQ-008 cfg_alpha  in  16 unsigned  smoothing factor, Q0.16 fraction.
REQ-009 cfg_mode  in  1  0 = low-pass, 1 = high-pass.
REQ-010 cfg_enable  in  1  channel enable.
REQ-011 clr_overrun  in  1  clears the overrun flag.
REQ-012 out  out  NUM_CHANNELS x 16 signed  filtered outputs, registered.
REQ-013 out_valid  out  1  one-clk pulse when out updates.
REQ-014 busy  out  1  high while a sample is being processed.
REQ-015 overrun  out  1  sticky; a strobe arrived while busy.
REQ-016 saturated  out  1  sticky; a result was clipped during the last sample.

Function
REQ-017 FSM states: IDLE, OPERAND, MULTIPLY, WRITEBACK, DONE.
REQ-018 IDLE plus audio_clk_en: latch all of in, plus alpha/mode/enable of every channel; set busy; channel index = 0; go to OPERAND.
REQ-019 Each channel takes OPERAND -> MULTIPLY -> WRITEBACK, one clk each; after WRITEBACK, index+1 -> OPERAND, or last channel -> DONE.
REQ-020 DONE: copy all channel states to out; pulse out_valid; clear busy; go to IDLE.
REQ-021 Latency fixed: out/out_valid update 3*NUM_CHANNELS+1 clk after the capturing edge (13 for the default).
REQ-022 Low-pass: y <= y + ((alpha * (x - y)) >>> 16).
REQ-023 High-pass: y <= (alpha * (y + x - x_prev)) >>> 16, then x_prev <= x.
REQ-024 Width rules:
  - difference term 18-bit signed
  - alpha zero-extended to 17-bit signed
  - product 35-bit signed
  - >>> is arithmetic (floor)
  - result saturated to [-32768, 32767]
  - a clip sets saturated
REQ-025 saturated is cleared at each capture in IDLE.
REQ-026 Disabled channel: y and x_prev forced to 0, out = 0; its slot is still consumed, so latency is unchanged.
REQ-027 A cfg write is accepted in any state; registers update on the next edge and take effect at the next capture, never mid-sample.
REQ-028 audio_clk_en while busy (including DONE): sample dropped, overrun <= 1, processing continues.
REQ-029 overrun is cleared by clr_overrun; a simultaneous clr_overrun and new overrun event leaves overrun = 1.
REQ-030 cfg_addr >= NUM_CHANNELS: write ignored.

Reset
REQ-031 I_RST clears:
  - FSM -> IDLE
  - all y, x_prev and out -> 0
  - alpha -> 0, mode -> low-pass, enable -> 0
  - out_valid, busy, overrun, saturated -> 0
REQ-032 I_RST mid-sample aborts processing; out_valid does not pulse for the aborted sample.
REQ-033 I_RST has priority over audio_clk_en, cfg_we and clr_overrun on the same edge.

Structure
REQ-034 Shared package discrete_filter_pkg holds:
  - fsm state enum
  - mode enum
  - SIGNAL_WIDTH = 16
  - FRACTION_WIDTH = 16
  - saturation bounds
REQ-035 One sub-module, filter_mac_unit: combinational operand select, multiply, shift and saturate for one channel step, with a saturation flag output.

Verification
REQ-036 Ch0 LP, alpha=32768, enabled; in[0]=1000 for two strobes -> out[0]=500, then 750; out_valid exactly 13 clk after each strobe.
REQ-037 Ch1 HP, alpha=32768; in[1]=1000 for two strobes -> out[1]=500, then 250.
REQ-038 Ch2 HP, alpha=65535; in[2]=-32768, 32767, -32768 -> out[2]=-32768, 32766, then -32768 with saturated=1.
REQ-039 Second strobe 5 clk after the first -> overrun=1, only one out_valid; clr_overrun -> overrun=0.
REQ-040 cfg write of ch0 alpha at cycle 4 of processing -> the current sample uses the old alpha; the next sample uses the new alpha.
REQ-041 I_RST at cycle 7 of processing -> no out_valid; all outputs 0; the next strobe processes normally.
